line_mem: RTL and testbench
===========================

# line_mem

Line-wide synchronous memory that sits directly downstream of the memory controller and serves its single memory port. Each request reads or writes one full line of N_WORDS_PER_ADDR × BITSIZE bits, with a fixed, parameterised access latency and a one-cycle completion pulse. It replaces an ideal zero-latency memory, so controller and accessor timing can be exercised against realistic latency, request aborts and reset.

## Interface
- BITSIZE, 32, bits per word.
- N_WORDS_PER_ADDR, 4, words per line. LINE_BITS = N_WORDS_PER_ADDR×BITSIZE and must be a multiple of 8. LINE_BYTES = LINE_BITS/8, a power of two.
- MEM_SIZE, 1024, number of lines. Must be a power of two.
- LATENCY, 2, cycles from request acceptance to completion. Legal range 1..255.

- clk  in  1  clock; all state changes on the rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- addr_i  in  32  byte address. Line index = addr_i >> log2(LINE_BYTES); the low offset bits are ignored.
- data_i  in  LINE_BITS  write line.
- store_i  in  1  1 = write, 0 = read.
- valid_i  in  1  request; held with stable fields until valid_o.
- data_o  out  LINE_BITS  read line. Registered; reset value 0.
- valid_o  out  1  one-cycle completion pulse. Reset value 0.
- err_o  out  1  range error, present only with LINE_MEM_RANGE_CHECK_EN. Reset value 0.

## Operation
- Storage: MEM_SIZE×LINE_BITS array, not cleared by reset, zero at simulation time 0.
- FSM states: IDLE, BUSY, ACK, WAIT. Reset state is IDLE.
- IDLE: if valid_i=1 at an edge, capture addr_i, store_i and data_i; load cnt=LATENCY-1; go to BUSY. Inputs that change after capture are ignored.
- BUSY:
  - If valid_i=0 at an edge, abort: go to IDLE, no array write, no valid_o.
  - Otherwise, if cnt≠0, decrement cnt.
  - If cnt=0, execute the operation and go to ACK:
    - Store: array[idx] ← captured data; data_o unchanged.
    - Load: data_o ← array[idx].
- ACK: valid_o=1 for this cycle only. At the next edge go to IDLE if valid_i=0, otherwise go to WAIT.
- WAIT: stay until valid_i=0, then go to IDLE. A request held high past its ack is never executed twice.
- Index arithmetic: the line index uses log2(MEM_SIZE) bits; upper index bits wrap (modulo MEM_SIZE).
- Reset asserted mid-operation: immediately go to IDLE with valid_o=0, data_o=0 and err_o=0. A pending write is dropped and array contents are untouched.

## Timing
- Acceptance edge E0 → valid_o high in the cycle after edge E0+LATENCY.
  - LATENCY=1: valid_o is high in the second cycle after valid_i rises.
- Load data is valid on data_o in the same cycle valid_o is high, and holds until the next completed load.
- Minimum request spacing: valid_o cycle, then one cycle with valid_i=0, then the next acceptance. This matches a controller that returns to idle for one cycle after each completion.
- Throughput is one request per LATENCY+2 cycles.

## Configuration
- LINE_MEM_RANGE_CHECK_EN defined:
  - err_o exists.
  - Any address with a nonzero bit above the index field is out of range.
  - An out-of-range request completes with the normal latency: valid_o=1 with err_o=1 in the same cycle, data_o ← 0, and no array write.
  - err_o is 0 in every other cycle.
- Not defined: err_o is absent and upper address bits wrap silently.

## Test plan
- Defaults: store 0x40, data 128'h0123…CDEF → valid_o exactly 2 cycles after acceptance. Then load 0x4C → data_o=128'h0123…CDEF (offset bits ignored).
- Macro off: store 0x4000 with data 0xAA..AA → aliases line 0, and a load of 0x0 returns 0xAA..AA. Macro on, same store → err_o=1 with valid_o, data_o=0, and line 0 unchanged.
- LATENCY=4: store to 0x80, drop valid_i after 1 BUSY cycle → no valid_o. A subsequent load of 0x80 returns the prior contents.
- Hold valid_i high for 5 cycles after valid_o → exactly one valid_o pulse and one array write. After one low cycle, the next request is accepted.
- Drop resetn_i during BUSY of a store → valid_o=0 and data_o=0 asynchronously. A later load of that address returns the old data.
- Change addr_i and data_i during BUSY → the operation uses the values captured at acceptance.

Source files
------------

// File: rtl/line_mem.sv
// Line-wide synchronous memory with fixed access latency, request abort and one-cycle completion pulse.
// Define LINE_MEM_RANGE_CHECK_EN to add err_o and reject addresses above the index field.
module line_mem #(
  parameter int BITSIZE          = 32,
  parameter int N_WORDS_PER_ADDR = 4,
  parameter int MEM_SIZE         = 1024,
  parameter int LATENCY          = 2
) (
  input  logic                                clk,
  input  logic                                resetn_i,
  input  logic [31:0]                         addr_i,
  input  logic [N_WORDS_PER_ADDR*BITSIZE-1:0] data_i,
  input  logic                                store_i,
  input  logic                                valid_i,
  output logic [N_WORDS_PER_ADDR*BITSIZE-1:0] data_o,
  output logic                                valid_o
`ifdef LINE_MEM_RANGE_CHECK_EN
  ,
  output logic                                err_o
`endif
);

  localparam int LINE_BITS  = N_WORDS_PER_ADDR * BITSIZE;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(MEM_SIZE);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  // Upper index bits are dropped, so the line index wraps modulo MEM_SIZE.
  function automatic logic [IDX_W-1:0] line_idx(input logic [31:0] a);
    return IDX_W'(a >> OFF_W);
  endfunction

`ifdef LINE_MEM_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [31:0] a);
    return (a >> (OFF_W + IDX_W)) != 32'd0;
  endfunction
`endif

  logic [LINE_BITS-1:0] r_mem [MEM_SIZE];
  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic                 r_store;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [LINE_BITS-1:0] r_rdata;
  logic                 r_valid;
  logic                 w_accept;
  logic                 w_exec;
  logic                 w_oor;
  logic                 w_we;

`ifdef LINE_MEM_RANGE_CHECK_EN
  logic r_oor;
  logic r_err;
  assign w_oor = r_oor;
  assign err_o = r_err;
`else
  assign w_oor = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && valid_i;
  assign w_exec   = (r_state == S_BUSY) && valid_i && (r_cnt == 8'd0);
  assign w_we     = w_exec && r_store && !w_oor;
  assign data_o   = r_rdata;
  assign valid_o  = r_valid;

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_store <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
`ifdef LINE_MEM_RANGE_CHECK_EN
      r_oor   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef LINE_MEM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_INIT;
            r_store <= store_i;
`ifdef LINE_MEM_RANGE_CHECK_EN
            r_oor   <= out_of_range(addr_i);
`endif
          end
        end
        S_BUSY: begin
          // Dropping valid_i before completion aborts without side effects.
          if (!valid_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state <= S_ACK;
            r_valid <= 1'b1;
            if (w_oor) begin
              r_rdata <= '0;
`ifdef LINE_MEM_RANGE_CHECK_EN
              r_err   <= 1'b1;
`endif
            end else if (!r_store) begin
              r_rdata <= r_mem[r_idx];
            end
          end
        end
        S_ACK: begin
          r_state <= valid_i ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!valid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields and array are datapath only; reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= line_idx(addr_i);
      r_wdata <= data_i;
    end
    if (w_we) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_line_mem.sv
// Directed self-checking bench for line_mem: a LATENCY=2 and a LATENCY=4 instance share one request bus.
module tb_line_mem;
  localparam int LB = 128;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          store = 1'b0;
  logic          valid = 1'b0;
  logic          sel = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic [LB-1:0] data = '0;
  logic [LB-1:0] do2, do4, dout;
  logic          vo2, vo4, vo, v2, v4;
  logic          eo2, eo4, eo;
  int            n_chk = 0;
  int            n_pass = 0;

  localparam logic [LB-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LB-1:0] DA = {16{8'hAA}};
  localparam logic [LB-1:0] D5 = {16{8'h55}};

  assign v2   = valid & ~sel;
  assign v4   = valid & sel;
  assign vo   = sel ? vo4 : vo2;
  assign dout = sel ? do4 : do2;
  assign eo   = sel ? eo4 : eo2;

  always #5 clk = ~clk;

  line_mem #(.LATENCY(2)) dut2 (
    .clk(clk), .resetn_i(resetn), .addr_i(addr), .data_i(data), .store_i(store),
    .valid_i(v2), .data_o(do2), .valid_o(vo2)
`ifdef LINE_MEM_RANGE_CHECK_EN
    , .err_o(eo2)
`endif
  );

  line_mem #(.LATENCY(4)) dut4 (
    .clk(clk), .resetn_i(resetn), .addr_i(addr), .data_i(data), .store_i(store),
    .valid_i(v4), .data_o(do4), .valid_o(vo4)
`ifdef LINE_MEM_RANGE_CHECK_EN
    , .err_o(eo4)
`endif
  );

`ifndef LINE_MEM_RANGE_CHECK_EN
  assign eo2 = 1'b0;
  assign eo4 = 1'b0;
`endif

  // lat = edges from acceptance to the cycle valid_o is seen, -1 on timeout.
  task automatic do_req(input logic [31:0] a, input logic [LB-1:0] d, input logic st,
                        output int lat, output logic [LB-1:0] rd, output logic er);
    addr = a; data = d; store = st; valid = 1'b1;
    lat = -1; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (vo) begin
        lat = i; rd = dout; er = eo;
        break;
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_chk++; if (vo2 !== 1'b0) $display("FAIL reset_valid2 got %b want 0", vo2); else n_pass++;
    n_chk++; if (vo4 !== 1'b0) $display("FAIL reset_valid4 got %b want 0", vo4); else n_pass++;
    n_chk++; if (do2 !== '0) $display("FAIL reset_data2 got %h want 0", do2); else n_pass++;
    n_chk++; if (do4 !== '0) $display("FAIL reset_data4 got %h want 0", do4); else n_pass++;
`ifdef LINE_MEM_RANGE_CHECK_EN
    n_chk++; if (eo2 !== 1'b0) $display("FAIL reset_err got %b want 0", eo2); else n_pass++;
`endif
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int lat; logic [LB-1:0] rd; logic er;
    do_req(32'h40, D1, 1'b1, lat, rd, er);
    n_chk++; if (lat !== 2) $display("FAIL store_latency got %0d want 2", lat); else n_pass++;
    n_chk++; if (rd !== '0) $display("FAIL store_data_o_held got %h want 0", rd); else n_pass++;
`ifdef LINE_MEM_RANGE_CHECK_EN
    n_chk++; if (er !== 1'b0) $display("FAIL store_err got %b want 0", er); else n_pass++;
`endif
    do_req(32'h4C, '0, 1'b0, lat, rd, er);
    n_chk++; if (lat !== 2) $display("FAIL load_latency got %0d want 2", lat); else n_pass++;
    n_chk++; if (rd !== D1) $display("FAIL load_offset got %h want %h", rd, D1); else n_pass++;
  endtask

  task automatic test_alias();
    int lat; logic [LB-1:0] rd; logic er;
    do_req(32'h0, D5, 1'b1, lat, rd, er);
    do_req(32'h4000, DA, 1'b1, lat, rd, er);
    n_chk++; if (lat !== 2) $display("FAIL alias_latency got %0d want 2", lat); else n_pass++;
`ifdef LINE_MEM_RANGE_CHECK_EN
    n_chk++; if (er !== 1'b1) $display("FAIL range_err got %b want 1", er); else n_pass++;
    n_chk++; if (rd !== '0) $display("FAIL range_data got %h want 0", rd); else n_pass++;
    do_req(32'h0, '0, 1'b0, lat, rd, er);
    n_chk++; if (rd !== D5) $display("FAIL range_line0 got %h want %h", rd, D5); else n_pass++;
    n_chk++; if (er !== 1'b0) $display("FAIL range_err_clear got %b want 0", er); else n_pass++;
`else
    n_chk++; if (rd !== D1) $display("FAIL alias_data_o_held got %h want %h", rd, D1); else n_pass++;
    do_req(32'h0, '0, 1'b0, lat, rd, er);
    n_chk++; if (rd !== DA) $display("FAIL alias_line0 got %h want %h", rd, DA); else n_pass++;
`endif
  endtask

  task automatic test_abort();
    int lat; int pulses; logic [LB-1:0] rd; logic er;
    logic [LB-1:0] p = 128'h11112222333344445555666677778888;
    sel = 1'b1;
    do_req(32'h80, p, 1'b1, lat, rd, er);
    n_chk++; if (lat !== 4) $display("FAIL lat4_store got %0d want 4", lat); else n_pass++;
    addr = 32'h80; data = ~p; store = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vo) pulses++;
    end
    n_chk++; if (pulses !== 0) $display("FAIL abort_pulses got %0d want 0", pulses); else n_pass++;
    do_req(32'h80, '0, 1'b0, lat, rd, er);
    n_chk++; if (lat !== 4) $display("FAIL lat4_load got %0d want 4", lat); else n_pass++;
    n_chk++; if (rd !== p) $display("FAIL abort_no_write got %h want %h", rd, p); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_hold();
    int lat; int pulses; logic [LB-1:0] rd; logic er;
    logic [LB-1:0] h = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
    addr = 32'hC0; data = h; store = 1'b1; valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vo) pulses++;
    end
    valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (pulses !== 1) $display("FAIL hold_pulses got %0d want 1", pulses); else n_pass++;
    do_req(32'hC0, '0, 1'b0, lat, rd, er);
    n_chk++; if (lat !== 2) $display("FAIL hold_next_latency got %0d want 2", lat); else n_pass++;
    n_chk++; if (rd !== h) $display("FAIL hold_data got %h want %h", rd, h); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [LB-1:0] rd; logic er;
    logic [LB-1:0] o = 128'h0BADBEEF0BADBEEF0BADBEEF0BADBEEF;
    do_req(32'h100, o, 1'b1, lat, rd, er);
    do_req(32'h100, '0, 1'b0, lat, rd, er);
    n_chk++; if (rd !== o) $display("FAIL rst_pre_load got %h want %h", rd, o); else n_pass++;
    addr = 32'h100; data = ~o; store = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    n_chk++; if (vo2 !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", vo2); else n_pass++;
    n_chk++; if (do2 !== '0) $display("FAIL rst_mid_data got %h want 0", do2); else n_pass++;
    valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_req(32'h100, '0, 1'b0, lat, rd, er);
    n_chk++; if (lat !== 2) $display("FAIL rst_post_latency got %0d want 2", lat); else n_pass++;
    n_chk++; if (rd !== o) $display("FAIL rst_write_dropped got %h want %h", rd, o); else n_pass++;
  endtask

  task automatic test_capture();
    int lat; logic [LB-1:0] rd; logic er;
    logic [LB-1:0] c0 = 128'hC0C0C0C0C0C0C0C0C0C0C0C0C0C0C0C0;
    logic [LB-1:0] c1 = 128'hC1C1C1C1C1C1C1C1C1C1C1C1C1C1C1C1;
    do_req(32'h180, c0, 1'b1, lat, rd, er);
    addr = 32'h140; data = c1; store = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    addr = 32'h180; data = ~c1; store = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (vo) begin lat = i; break; end
    end
    valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (lat !== 2) $display("FAIL capture_latency got %0d want 2", lat); else n_pass++;
    do_req(32'h140, '0, 1'b0, lat, rd, er);
    n_chk++; if (rd !== c1) $display("FAIL capture_written got %h want %h", rd, c1); else n_pass++;
    do_req(32'h180, '0, 1'b0, lat, rd, er);
    n_chk++; if (rd !== c0) $display("FAIL capture_other got %h want %h", rd, c0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_abort();
    test_hold();
    test_reset_mid();
    test_capture();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
